// File: rtl/rx_iq_axis_pack_pkg.sv
// Shared types and constants for the RX IQ AXI-Stream packer.
package rx_iq_axis_pack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ABORT,
    ST_DRAIN
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = 16;
  localparam int TS_W       = 64;

  localparam logic [63:0] ABORT_BEAT = 64'h0;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry AXI-Stream skid buffer, {data, last} payload.
// Head entry drives the registered stream outputs.
module axis_skid2
  import rx_iq_axis_pack_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  output logic         accept,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast
);

  logic [1:0]   cnt;
  logic [W-1:0] d0, d1;
  logic         l0, l1;
  logic         pop, do_push;

  assign m_tvalid = (cnt != 2'd0);
  assign m_tdata  = d0;
  assign m_tlast  = l0;
  assign pop      = m_tvalid & m_tready;
  assign accept   = (cnt != 2'(SKID_DEPTH)) | pop;
  assign do_push  = push & accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      unique case ({do_push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            d0 <= push_data;
            l0 <= push_last;
          end else begin
            d1 <= push_data;
            l1 <= push_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          // Keep the head unchanged when emptying so tdata holds its value.
          if (cnt == 2'd2) begin
            d0 <= d1;
            l0 <= l1;
          end
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            d0 <= push_data;
            l0 <= push_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= push_data;
            l1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rx_iq_axis_pack.sv
// RX IQ word stream to framed AXI4-Stream master with skid buffer.
// Define RX_IQ_AXIS_PACK_TIMESTAMP_EN for a per-frame timestamp header beat.
module rx_iq_axis_pack
  import rx_iq_axis_pack_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int FRAME_LEN_WIDTH        = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] rf_iq,
  input  logic                              rf_iq_valid,
  input  logic                              cap_en,
  input  logic                              cap_start,
  input  logic [FRAME_LEN_WIDTH-1:0]        frame_len,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              busy,
  output logic [CNT_W-1:0]                  overflow_cnt,
  output logic [CNT_W-1:0]                  frame_cnt
);

  localparam int DW = C_M00_AXIS_TDATA_WIDTH;

  state_e                     state;
  logic [FRAME_LEN_WIDTH-1:0] len_q;
  logic [FRAME_LEN_WIDTH-1:0] beat_cnt;

  logic          accept, pop;
  logic          is_last, start_ok;
  logic          cap_push, abort_push;
  logic          push, push_last;
  logic [DW-1:0] push_data;

  assign pop        = m_axis_tvalid & m_axis_tready;
  assign is_last    = (beat_cnt == len_q - 1'b1);
  assign start_ok   = (state == ST_IDLE) & cap_start & cap_en;
  assign cap_push   = (state == ST_CAPTURE) & rf_iq_valid & accept;
  assign abort_push = (state == ST_ABORT) & accept;

`ifdef RX_IQ_AXIS_PACK_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else if (rf_iq_valid) ts_q <= ts_q + 1'b1;
  end
`endif

  always_comb begin
    push      = 1'b0;
    push_data = rf_iq;
    push_last = is_last;
    unique case (1'b1)
      cap_push: push = 1'b1;
      abort_push: begin
        push      = 1'b1;
        push_data = DW'(ABORT_BEAT);
        push_last = 1'b1;
      end
`ifdef RX_IQ_AXIS_PACK_TIMESTAMP_EN
      start_ok: begin
        push      = 1'b1;
        push_data = DW'(ts_q);
        push_last = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  axis_skid2 #(.W(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .push_last (push_last),
    .accept    (accept),
    .m_tdata   (m_axis_tdata),
    .m_tvalid  (m_axis_tvalid),
    .m_tready  (m_axis_tready),
    .m_tlast   (m_axis_tlast)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      len_q        <= FRAME_LEN_WIDTH'(1);
      beat_cnt     <= '0;
      overflow_cnt <= '0;
      frame_cnt    <= '0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_ok) begin
            len_q        <= (frame_len == '0) ? FRAME_LEN_WIDTH'(1)
                                              : frame_len;
            beat_cnt     <= '0;
            overflow_cnt <= '0;
            busy         <= 1'b1;
            state        <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // Drops never advance beat_cnt, so frames keep len_q beats.
          if (rf_iq_valid) begin
            if (accept) beat_cnt <= beat_cnt + 1'b1;
            else overflow_cnt <= sat_inc(overflow_cnt);
          end
          if (cap_push & is_last) state <= ST_DRAIN;
          else if (!cap_en) state <= ST_ABORT;
        end
        ST_ABORT: begin
          if (accept) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop & m_axis_tlast) begin
            frame_cnt <= frame_cnt + 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_iq_axis_pack.sv
// Scoreboard bench for rx_iq_axis_pack.
// Covers timestamp header when RX_IQ_AXIS_PACK_TIMESTAMP_EN is defined.
module tb_rx_iq_axis_pack;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] rf_iq = '0;
  logic        rf_iq_valid = 1'b0;
  logic        cap_en = 1'b1;
  logic        cap_start = 1'b0;
  logic [11:0] frame_len = '0;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        busy;
  logic [15:0] ovf;
  logic [15:0] fcnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  beat_t       exp_q[$];
  longint unsigned ts_model = 0;
  logic [15:0] frames_model = 0;

  always #5 clk = ~clk;

  rx_iq_axis_pack dut (
    .clk           (clk),
    .rst           (rst),
    .rf_iq         (rf_iq),
    .rf_iq_valid   (rf_iq_valid),
    .cap_en        (cap_en),
    .cap_start     (cap_start),
    .frame_len     (frame_len),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .overflow_cnt  (ovf),
    .frame_cnt     (fcnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] len);
    frame_len = len;
    cap_en    = 1'b1;
    cap_start = 1'b1;
`ifdef RX_IQ_AXIS_PACK_TIMESTAMP_EN
    exp_q.push_back({64'(ts_model), 1'b0});
`endif
    step();
    cap_start = 1'b0;
  endtask

  task automatic send(input logic [63:0] d);
    rf_iq       = d;
    rf_iq_valid = 1'b1;
    ts_model++;
    step();
    rf_iq_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic scoreboard();
    logic [63:0] pd = '0;
    logic        pl = 1'b0;
    bit          stall = 1'b0;
    beat_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          n_tests++;
          if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
            n_fail++;
            $display("FAIL stall_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     tvalid, tdata, tlast, pd, pl);
          end
        end
        if (tvalid === 1'b1 && tready === 1'b1) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got d=%h l=%b want none",
                     tdata, tlast);
          end else begin
            e = exp_q.pop_front();
            if (tdata !== e.d || tlast !== e.l) begin
              n_fail++;
              $display("FAIL beat: got d=%h l=%b want d=%h l=%b",
                       tdata, tlast, e.d, e.l);
            end
          end
        end
        stall = (tvalid === 1'b1 && tready !== 1'b1);
        pd = tdata;
        pl = tlast;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests += 6;
    if (tdata !== 64'h0) begin n_fail++; $display("FAIL rst_tdata: got %h want 0", tdata); end
    if (tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", tvalid); end
    if (tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b want 0", tlast); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (ovf !== 16'h0) begin n_fail++; $display("FAIL rst_ovf: got %0d want 0", ovf); end
    if (fcnt !== 16'h0) begin n_fail++; $display("FAIL rst_fcnt: got %0d want 0", fcnt); end
    rst = 1'b0;
    ts_model = 0;
    frames_model = 0;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    logic [63:0] d;
    tready = 1'b1;
    do_start(12'd4);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      d = 64'hA5A5_0000_0000_0000 | 64'(i * 17 + 3);
      exp_q.push_back({d, i == 3});
      send(d);
      if (i == 0) begin
        n_tests++;
        if (tvalid !== 1'b1 || tdata !== d) begin
          n_fail++;
          $display("FAIL basic_latency: got v=%b d=%h want v=1 d=%h", tvalid, tdata, d);
        end
      end
    end
    wait_done(ok);
    frames_model++;
    n_tests += 3;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: got busy=%b want 0", busy); end
    if (fcnt !== frames_model) begin n_fail++; $display("FAIL basic_fcnt: got %0d want %0d", fcnt, frames_model); end
    if (ovf !== 16'h0) begin n_fail++; $display("FAIL basic_ovf: got %0d want 0", ovf); end
  endtask

  task automatic test_idle_valid();
    for (int i = 0; i < 5; i++) send(64'hDEAD_0000 + 64'(i));
    step();
    n_tests += 3;
    if (tvalid !== 1'b0) begin n_fail++; $display("FAIL idle_tvalid: got %b want 0", tvalid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    if (ovf !== 16'h0) begin n_fail++; $display("FAIL idle_ovf: got %0d want 0", ovf); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [63:0] d;
    int acc = 0;
    tready = 1'b1;
    do_start(12'd8);
    step();
    for (int i = 0; i < 12; i++) begin
      tready = (i >= 6);
      d = 64'hB000_0000_0000_0000 | 64'(i);
      if (i < 2 || i >= 6) begin
        acc++;
        exp_q.push_back({d, acc == 8});
      end
      send(d);
    end
    tready = 1'b1;
    wait_done(ok);
    frames_model++;
    n_tests += 3;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout: got busy=%b want 0", busy); end
    if (ovf !== 16'd4) begin n_fail++; $display("FAIL bp_ovf: got %0d want 4", ovf); end
    if (fcnt !== frames_model) begin n_fail++; $display("FAIL bp_fcnt: got %0d want %0d", fcnt, frames_model); end
    send(64'h1234);
    n_tests++;
    if (ovf !== 16'd4) begin n_fail++; $display("FAIL bp_idle_ovf: got %0d want 4", ovf); end
  endtask

  task automatic test_abort();
    bit ok;
    logic [63:0] d;
    tready = 1'b1;
    do_start(12'd100);
    for (int i = 0; i < 3; i++) begin
      d = 64'hC0C0_0000_0000_0000 | 64'(i + 1);
      exp_q.push_back({d, 1'b0});
      send(d);
    end
    exp_q.push_back({64'h0, 1'b1});
    cap_en = 1'b0;
    step();
    wait_done(ok);
    cap_en = 1'b1;
    frames_model++;
    n_tests += 3;
    if (!ok) begin n_fail++; $display("FAIL abort_timeout: got busy=%b want 0", busy); end
    if (fcnt !== frames_model) begin n_fail++; $display("FAIL abort_fcnt: got %0d want %0d", fcnt, frames_model); end
    step();
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_edge();
    bit ok;
    tready = 1'b1;
    do_start(12'd0);
    exp_q.push_back({64'hE0, 1'b1});
    send(64'hE0);
    wait_done(ok);
    frames_model++;
    n_tests += 2;
    if (!ok) begin n_fail++; $display("FAIL len0_timeout: got busy=%b want 0", busy); end
    if (fcnt !== frames_model) begin n_fail++; $display("FAIL len0_fcnt: got %0d want %0d", fcnt, frames_model); end
    do_start(12'd3);
    exp_q.push_back({64'hE1, 1'b0});
    send(64'hE1);
    cap_start = 1'b1;
    frame_len = 12'd1;
    exp_q.push_back({64'hE2, 1'b0});
    send(64'hE2);
    cap_start = 1'b0;
    exp_q.push_back({64'hE3, 1'b1});
    send(64'hE3);
    wait_done(ok);
    frames_model++;
    n_tests += 2;
    if (!ok) begin n_fail++; $display("FAIL restart_timeout: got busy=%b want 0", busy); end
    if (fcnt !== frames_model) begin n_fail++; $display("FAIL restart_fcnt: got %0d want %0d", fcnt, frames_model); end
  endtask

`ifdef RX_IQ_AXIS_PACK_TIMESTAMP_EN
  task automatic test_timestamp();
    bit ok;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ts_model = 0;
    frames_model = 0;
    for (int i = 0; i < 10; i++) send(64'h7700 + 64'(i));
    n_tests++;
    if (ts_model != 10) begin n_fail++; $display("FAIL ts_setup: got %0d want 10", ts_model); end
    do_start(12'd2);
    exp_q.push_back({64'hF1, 1'b0});
    send(64'hF1);
    exp_q.push_back({64'hF2, 1'b1});
    send(64'hF2);
    wait_done(ok);
    frames_model++;
    n_tests += 2;
    if (!ok) begin n_fail++; $display("FAIL ts_timeout: got busy=%b want 0", busy); end
    if (fcnt !== frames_model) begin n_fail++; $display("FAIL ts_fcnt: got %0d want %0d", fcnt, frames_model); end
  endtask
`endif

  task automatic test_reset_mid();
    tready = 1'b1;
    do_start(12'd8);
    step();
    tready = 1'b0;
    for (int i = 0; i < 4; i++) send(64'h9900 + 64'(i));
    n_tests += 2;
    if (ovf !== 16'd2) begin n_fail++; $display("FAIL mid_pre_ovf: got %0d want 2", ovf); end
    if (tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_tvalid: got %b want 1", tvalid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    ts_model = 0;
    frames_model = 0;
    n_tests += 4;
    if (tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid: got %b want 0", tvalid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (ovf !== 16'h0) begin n_fail++; $display("FAIL mid_ovf: got %0d want 0", ovf); end
    if (fcnt !== 16'h0) begin n_fail++; $display("FAIL mid_fcnt: got %0d want 0", fcnt); end
    tready = 1'b1;
    step();
    step();
    n_tests++;
    if (tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_post_tvalid: got %b want 0", tvalid); end
  endtask

  initial begin
    fork
      scoreboard();
    join_none
    test_reset();
    test_basic();
    test_idle_valid();
    test_backpressure();
    test_abort();
    test_edge();
`ifdef RX_IQ_AXIS_PACK_TIMESTAMP_EN
    test_timestamp();
`endif
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_beats: got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_iq_axis_pack.md
# rx_iq_axis_pack

Downstream neighbour of the RX IQ interface FIFO. It consumes the 64-bit `rf_iq` word stream and its valid strobe, and captures software-requested frames of a programmable beat count. It emits the frame as an AXI4-Stream master, with `tlast` on the final beat, toward the DMA loopback path. A 2-entry skid buffer gives full throughput under backpressure; samples that cannot be buffered are dropped and counted.

## Interface
- `C_M00_AXIS_TDATA_WIDTH`, 64, stream and sample word width.
- `FRAME_LEN_WIDTH`, 12, width of the beat-count register.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, synchronous, active-high.
- `rf_iq`  in  64  IQ word from the RX IQ FIFO.
- `rf_iq_valid`  in  1  one-cycle strobe qualifying `rf_iq`; at most one per cycle.
- `cap_en`  in  1  capture enable; low aborts an active frame.
- `cap_start`  in  1  one-cycle start pulse; honoured only in IDLE with `cap_en`=1.
- `frame_len`  in  12  sample beats per frame; sampled at start; 0 is treated as 1.
- `m_axis_tdata`  out  64  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  final beat of a frame.
- `busy`  out  1  high in any state other than IDLE.
- `overflow_cnt`  out  16  dropped samples; saturates at 0xFFFF; cleared at each accepted start.
- `frame_cnt`  out  16  completed or aborted frames; wraps.

## Operation
- **FSM states:** IDLE, CAPTURE, ABORT, DRAIN.
- **IDLE → CAPTURE:** on `cap_start & cap_en`.
  - Latch `max(frame_len,1)` into `len_q`.
  - Clear `beat_cnt` and `overflow_cnt`.
- **CAPTURE, per `rf_iq_valid`:**
  - If the buffer can accept, push {`rf_iq`, last = (`beat_cnt`==`len_q`-1)} and increment `beat_cnt`.
  - Otherwise drop the sample and increment `overflow_cnt` (saturating). Dropped samples do not advance `beat_cnt`, so every frame carries exactly `len_q` sample beats.
- **CAPTURE → DRAIN:** on the cycle the last-flagged beat is pushed.
- **CAPTURE → ABORT:** when `cap_en`=0 and no last beat is pushed that cycle.
  - ABORT pushes one beat {tdata=0, last=1} as soon as the buffer has room, then goes to DRAIN.
  - `rf_iq_valid` is ignored in ABORT.
- **DRAIN → IDLE:** when the last-flagged beat handshakes (`tvalid & tready & tlast`). `frame_cnt` increments on that cycle.
- **Outside CAPTURE:** `rf_iq_valid` is ignored. It is not counted as overflow.
- **Buffer acceptance:** the buffer accepts a push when it has fewer than 2 entries, or when it has 2 entries and a pop occurs in the same cycle.
- **Stream rules:**
  - Output data is registered.
  - `tvalid` never drops while `tready`=0.
  - `tdata` and `tlast` are stable while `tvalid & ~tready`.
- **`cap_start` outside IDLE:** ignored.
- **`rst` mid-frame:** returns to IDLE, empties the buffer, zeroes `tvalid`, and clears both counters. No partial beat is emitted.

## Timing
- **Reset values:** `m_axis_tdata`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `busy`=0, `overflow_cnt`=0, `frame_cnt`=0.
- **Start:** `cap_start` at cycle N puts the FSM in CAPTURE at N+1, so the first capturable `rf_iq_valid` is at N+1.
- **Latency:** `rf_iq_valid` at cycle K with an empty buffer gives `m_axis_tvalid`=1 with that data at K+1.
- **Throughput:** one beat per cycle sustained while `tready`=1. No drops unless `tready` is low long enough for 2 beats to accumulate.
- **`busy`:** rises at N+1 and falls the cycle after the `tlast` handshake.

## Configuration
- **`RX_IQ_AXIS_PACK_TIMESTAMP_EN` defined:**
  - A 64-bit free-running counter increments on every `rf_iq_valid` from reset.
  - On the accepted-start cycle N, a header beat {tdata = counter value at N, last=0} is pushed. The buffer is empty in IDLE, so this push always succeeds.
  - Header beats do not count toward `len_q`.
  - The first sample may be captured at N+1, as before.
- **Undefined:** no counter and no header. A frame is exactly `len_q` sample beats, or the partial count plus the zero tlast beat on abort.

## Structure
- **Package `rx_iq_axis_pack_pkg`:**
  - FSM state enum.
  - Skid depth constant (2).
  - Counter widths (16; 64 for the timestamp).
  - Abort beat pattern (0).
- **Sub-module `axis_skid2`:** 2-entry AXI-Stream skid buffer with a {data, last} payload and push/full-or-accept/pop ports, reused by the pack FSM.

## Test plan
- **Basic frame:** `frame_len`=4, `tready`=1, 4 valids on consecutive cycles → 4 beats with data matching, `tlast` on beat 4 only, `frame_cnt`=1, `overflow_cnt`=0.
- **Backpressure:** `frame_len`=8, `tready` low for 6 cycles during continuous valids → exactly 8 beats delivered in order, `overflow_cnt`=4, `tlast` on the 8th delivered beat, `tdata` stable while stalled.
- **Abort:** `frame_len`=100, `cap_en` drops after 3 samples → 3 data beats plus one beat tdata=0/`tlast`=1, `frame_cnt`=1, `busy` low afterward.
- **Edge cases:**
  - `frame_len`=0 gives a 1-beat frame with `tlast`.
  - `cap_start` during CAPTURE is ignored.
  - `rf_iq_valid` in IDLE gives no beats and `overflow_cnt` stays 0.
- **Timestamp (macro on):** 10 valids before `cap_start`, then `frame_len`=2 → header tdata=10 with `tlast`=0, then 2 samples with `tlast` on the second.
- **Reset mid-frame:** `rst` asserted with 2 beats buffered and `tready`=0 → next cycle `tvalid`=0, `busy`=0, both counters 0.
